// File: rtl/div_pkg.sv
// Shared constants for the sequential restoring divider: FSM encoding,
// default operand width and iteration counter width.
package div_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam int DIV_WIDTH = 4;
  // Wide enough to hold WIDTH=16 as a start count.
  localparam int CNT_W     = 5;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift {A,Q} left, trial-subtract M,
// and keep the difference only when it is non-negative.
module div_step
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] q_i,
  input  logic [WIDTH-1:0] m_i,
  output logic [WIDTH-1:0] a_o,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH:0] shift_a;
  logic [WIDTH:0] trial;

  // A < M always holds, so the shifted A needs one extra bit but the kept
  // difference always fits back into WIDTH bits.
  assign shift_a = {a_i, q_i[WIDTH-1]};
  assign trial   = shift_a - {1'b0, m_i};

  assign a_o = trial[WIDTH] ? shift_a[WIDTH-1:0] : trial[WIDTH-1:0];
  assign q_o = {q_i[WIDTH-2:0], ~trial[WIDTH]};

endmodule

// File: rtl/seq_divider.sv
// Sequential restoring divider, one quotient bit per clock, start/busy/done
// handshake. Define SEQ_DIVIDER_SIGNED_EN for two's-complement operands.
//
//  state   | meaning
//  IDLE    | waiting for start
//  RUN     | iterating, one quotient bit per edge
//  DONE    | one-cycle done pulse; start here is accepted back-to-back
module seq_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH-1:0] step_a, step_q;
  logic [WIDTH-1:0] dvd_mag, dvs_mag;
  logic [WIDTH-1:0] quot_fix, rem_fix;

`ifdef SEQ_DIVIDER_SIGNED_EN
  logic neg_quot_q, neg_quot_d;
  logic neg_rem_q, neg_rem_d;

  // The most-negative value's magnitude still fits as an unsigned WIDTH-bit number.
  assign dvd_mag  = dividend[WIDTH-1] ? -dividend : dividend;
  assign dvs_mag  = divisor[WIDTH-1]  ? -divisor  : divisor;
  assign quot_fix = neg_quot_q ? -step_q : step_q;
  assign rem_fix  = neg_rem_q  ? -step_a : step_a;
`else
  assign dvd_mag  = dividend;
  assign dvs_mag  = divisor;
  assign quot_fix = step_q;
  assign rem_fix  = step_a;
`endif

  div_step #(.WIDTH(WIDTH)) u_step (
    .a_i (a_q),
    .q_i (q_q),
    .m_i (m_q),
    .a_o (step_a),
    .q_o (step_q)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    q_d     = q_q;
    m_d     = m_q;
    cnt_d   = cnt_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
`ifdef SEQ_DIVIDER_SIGNED_EN
    neg_quot_d = neg_quot_q;
    neg_rem_d  = neg_rem_q;
`endif
    case (state_q)
      ST_RUN: begin
        a_d   = step_a;
        q_d   = step_q;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_DONE;
          quot_d  = quot_fix;
          rem_d   = rem_fix;
        end
      end
      default: begin
        state_d = ST_IDLE;
        if (start) begin
          m_d   = dvs_mag;
          q_d   = dvd_mag;
          a_d   = '0;
          cnt_d = CNT_W'(WIDTH);
          dbz_d = (divisor == '0);
`ifdef SEQ_DIVIDER_SIGNED_EN
          neg_quot_d = dividend[WIDTH-1] ^ divisor[WIDTH-1];
          neg_rem_d  = dividend[WIDTH-1];
`endif
          if (divisor == '0) begin
            state_d = ST_DONE;
            quot_d  = '1;
            rem_d   = dividend;
          end else begin
            state_d = ST_RUN;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      q_q     <= '0;
      m_q     <= '0;
      cnt_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      q_q     <= q_d;
      m_q     <= m_d;
      cnt_q   <= cnt_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
`ifdef SEQ_DIVIDER_SIGNED_EN
      neg_quot_q <= neg_quot_d;
      neg_rem_q  <= neg_rem_d;
`endif
    end
  end

  assign busy        = (state_q == ST_RUN);
  assign done        = (state_q == ST_DONE);
  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
Sequential restoring divider, one quotient bit per clock. It is the inverse counterpart of the team's shift-add multiplier. It takes an unsigned dividend/divisor pair on a start pulse and returns quotient and remainder after a fixed latency. The multi-cycle done handshake lets it serve as the arithmetic unit beside the register memory in lab-level datapaths.

Parameters:
WIDTH, 4, operand/result width in bits (legal range 2..16)

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
start  input  1  request; sampled only when busy=0
dividend  input  WIDTH  numerator, captured on accepted start
divisor  input  WIDTH  denominator, captured on accepted start
busy  output  1  high while iterating
done  output  1  one-cycle pulse when results become valid
quotient  output  WIDTH  result quotient, held until next accepted start
remainder  output  WIDTH  result remainder, held until next accepted start
div_by_zero  output  1  high with results when captured divisor == 0; held with results

Behaviour:
- Reset: rst sampled high at a clk edge forces:
  - state=IDLE; busy=0, done=0, div_by_zero=0
  - quotient=0, remainder=0; internal A, Q, M and count cleared
  - Applies from any state, including mid-RUN; the partial result is discarded.
- FSM states: IDLE, RUN, DONE.
  - IDLE/DONE, start=1: capture M=divisor, Q=dividend, A=0, count=WIDTH.
    - If divisor != 0: go to RUN, busy=1.
    - If divisor == 0: go to DONE directly.
  - IDLE/DONE, start=0: stay. DONE falls to IDLE after one cycle; done is high only in DONE.
  - RUN: one iteration per edge.
    - {A,Q} shifted left by 1.
    - Trial T = A - M, computed WIDTH+1 bits wide.
    - If T negative: Q[0]=0 and A is unchanged (restore). Otherwise A=T[WIDTH-1:0] and Q[0]=1.
    - Decrement count. The edge with count==1 performs the last iteration, moves to DONE, and registers quotient=Q and remainder=A.
- Latency:
  - Nonzero divisor: done rises WIDTH+1 edges after the edge that accepted start. That is 1 load edge plus WIDTH iteration edges; with WIDTH=4, done is visible after the 5th edge.
  - Zero divisor: done rises 1 edge after accept.
- Divide by zero: quotient = all ones, remainder = dividend, div_by_zero=1. No iterations run.
- start while busy=1 is ignored; operand changes during RUN have no effect.
- start sampled in DONE is accepted. This gives back-to-back operation: done pulses and the new load occur on the same edge, with no IDLE cycle.
- busy and done are never high together.
- Outputs are registered and only change on accepted completion or reset. div_by_zero clears on the next accepted start.
- Arithmetic invariant when divisor != 0: dividend == quotient*divisor + remainder, and remainder < divisor.

Optional Feature:
Macro SEQ_DIVIDER_SIGNED_EN.
- Defined:
  - Operands are two's complement. The divider captures their magnitudes and divides unsigned.
  - On the final edge it negates the quotient if the operand signs differ, and negates the remainder if the dividend is negative. This gives truncation toward zero; latency is unchanged.
  - Divide by zero returns quotient = all ones (-1), remainder = dividend.
  - Most-negative / -1 returns quotient = most-negative and remainder = 0.
- Undefined: unsigned only, with no sign logic synthesized.

Decomposition:
- Shared package div_pkg:
  - State encoding constants ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2
  - Default width constant DIV_WIDTH=4
  - Counter width CNT_W=5, sized for WIDTH up to 16
- Sub-module div_step: purely combinational, one restoring iteration. Inputs A, Q, M; outputs next A and next Q. Instanced once inside seq_divider and unit-testable standalone.

Test Plan:
1. WIDTH=4, start with 13/3 → busy for 4 cycles, done pulse after 5th edge, quotient=4, remainder=1, div_by_zero=0.
2. 15/15 → quotient=1, remainder=0. 7/9 → quotient=0, remainder=7. 0/5 → quotient=0, remainder=0.
3. 9/0 → done after 1 edge, quotient=4'b1111, remainder=9, div_by_zero=1. Then 8/2 clears the flag, giving quotient=4, remainder=0.
4. Start 12/5, then pulse start with 1/1 on the second RUN cycle → the second start is ignored; result is quotient=2, remainder=2. Start 6/4 held high during DONE → accepted back-to-back, result quotient=1, remainder=2.
5. Start 14/3, assert rst for one edge during the 3rd RUN cycle → the next edge shows busy=0, done=0, quotient=0, remainder=0. A subsequent 14/3 yields quotient=4, remainder=2.
6. SEQ_DIVIDER_SIGNED_EN defined, -7/2 (4'b1001 / 4'b0010) → quotient=4'b1101 (-3), remainder=4'b1111 (-1). -8/-1 → quotient=4'b1000, remainder=0.
